// File: rtl/ex_muldiv_unit_pkg.sv
// Shared decode constants and FSM encoding for the EX-stage RV32M multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ex_muldiv_unit_iter_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply or restoring divide, one bit per cycle.
module muldiv_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            div_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            last_o,
    output logic [XLEN-1:0] hi_d_o,
    output logic [XLEN-1:0] lo_d_o
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [CW-1:0]   cnt_q;
    logic            div_q;
    logic [XLEN:0]   add_sum, trial;

    // hi holds the upper product / partial remainder; lo holds the multiplier / dividend-then-quotient
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        trial   = {hi_q, lo_q[XLEN-1]} - {1'b0, b_q};
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (div_q) begin
            if (!trial[XLEN]) begin
                hi_d = trial[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = add_sum[XLEN:1];
            lo_d = {add_sum[0], lo_q[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            hi_q  <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
            cnt_q <= CW'(XLEN);
            div_q <= div_i;
        end else if (cnt_q != '0) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign last_o = (cnt_q == CW'(1));
    assign hi_d_o = hi_d;
    assign lo_d_o = lo_d;

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit in EX: decode, special cases, sign fix-up and the IDLE/BUSY/DONE control FSM.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_o,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    state_t state_q, state_d;

    logic [2:0]      funct3, op_q;
    logic            is_m, s1_signed, s2_signed, n1, n2, res_neg, neg_q;
    logic            div_zero, div_ovf, special;
    logic            start, start_normal, start_special, finish, last;
    logic [XLEN-1:0] mag1, mag2, spec_val, hi_d, lo_d, final_val;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_lat_q, rd_out_q, rd_out_d;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic            unused_instr_bits;

    assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};

    assign funct3    = instruction[14:12];
    assign is_m      = (instruction[6:0] == OP_REG) && (instruction[31:25] == F7_MULDIV);
    assign s1_signed = (funct3 == MD_MULH) || (funct3 == MD_MULHSU) || (funct3 == MD_DIV) || (funct3 == MD_REM);
    assign s2_signed = (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
    assign n1        = s1_signed & rs1_val[XLEN-1];
    assign n2        = s2_signed & rs2_val[XLEN-1];
    assign mag1      = n1 ? -rs1_val : rs1_val;
    assign mag2      = n2 ? -rs2_val : rs2_val;
    assign res_neg   = (funct3 == MD_REM) ? n1 : (n1 ^ n2);

    assign div_zero  = funct3[2] && (rs2_val == '0);
    assign div_ovf   = ((funct3 == MD_DIV) || (funct3 == MD_REM))
                       && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
    assign special   = div_zero | div_ovf;
    assign spec_val  = div_zero ? (funct3[1] ? rs1_val : '1)
                                : (funct3[1] ? '0 : rs1_val);

    assign start         = instr_valid & is_m & ~flush & ~reset & (state_q == ST_IDLE);
    assign start_normal  = start & ~special;
    assign start_special = start & special;
    assign finish        = (state_q == ST_BUSY) & ~flush & last;

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load_i (start_normal),
        .div_i  (funct3[2]),
        .a_i    (mag1),
        .b_i    (mag2),
        .last_o (last),
        .hi_d_o (hi_d),
        .lo_d_o (lo_d)
    );

    // the final iteration's step is fixed up and captured directly, so result is ready on entry to DONE
    always_comb begin
        prod     = {hi_d, lo_d};
        prod_fix = neg_q ? -prod : prod;
        case (op_q)
            MD_MUL:                        final_val = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  final_val = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               final_val = neg_q ? -lo_d : lo_d;
            default:                       final_val = neg_q ? -hi_d : hi_d;
        endcase
        result_d = result_q;
        rd_out_d = rd_out_q;
        if (start_special) begin
            result_d = spec_val;
            rd_out_d = rd_in;
        end else if (finish) begin
            result_d = final_val;
            rd_out_d = rd_lat_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rd_lat_q <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            if (start_normal) begin
                op_q     <= funct3;
                neg_q    <= res_neg;
                rd_lat_q <= rd_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = special ? ST_DONE : ST_BUSY;
            ST_BUSY: begin
                if (flush)     state_d = ST_IDLE;
                else if (last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        result_valid = (state_q == ST_DONE) & ~flush;
        stall_o      = start_normal | ((state_q == ST_BUSY) & ~flush);
    end

    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: latency, signed/unsigned results, specials, flush and reset.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        stall_o, result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int d1, d2;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instruction  (instruction),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .rd_in        (rd_in),
        .flush        (flush),
        .stall_o      (stall_o),
        .result_valid (result_valid),
        .result       (result),
        .rd_out       (rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, OP_REG};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one M op in cycle T and hold it until its DONE cycle T+lat.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat,
                         output int done_cyc);
        @(posedge clk); #1;
        instr_valid = 1'b1;
        instruction = mk(F7_MULDIV, f3, rd);
        rs1_val = a; rs2_val = b; rd_in = rd;
        #1;
        for (int i = 0; i < lat; i++) begin
            chk("stall_busy", {31'd0, stall_o}, {31'd0, lat > 1});
            chk("valid_early", {31'd0, result_valid}, 32'd0);
            @(posedge clk); #2;
        end
        chk("valid_done", {31'd0, result_valid}, 32'd1);
        chk("stall_done", {31'd0, stall_o}, 32'd0);
        chk("result", result, exp);
        chk("rd_out", {27'd0, rd_out}, {27'd0, rd});
        done_cyc = cyc;
    endtask

    task automatic bubble();
        @(posedge clk); #1;
        instr_valid = 1'b0;
        flush = 1'b0;
        #1;
        chk("bubble_valid", {31'd0, result_valid}, 32'd0);
        chk("bubble_stall", {31'd0, stall_o}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        reset = 1'b0;

        do_op(MD_MUL, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33, d1); bubble();
        do_op(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 33, d1); bubble();
        do_op(MD_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000, 33, d1); bubble();
        do_op(MD_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd4, 32'hFFFFFFFF, 33, d1); bubble();
        do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 33, d1); bubble();
        do_op(MD_REM, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 33, d1); bubble();
        do_op(MD_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 33, d1); bubble();
        do_op(MD_REMU, 32'd100, 32'd7, 5'd8, 32'd2, 33, d1); bubble();

        // asynchronous reset in the middle of a DIVU
        @(posedge clk); #1;
        instr_valid = 1'b1;
        instruction = mk(F7_MULDIV, MD_DIVU, 5'd9);
        rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd9;
        repeat (5) @(posedge clk);
        #1; reset = 1'b1; #1;
        chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
        chk("mid_rst_valid", {31'd0, result_valid}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_rd", {27'd0, rd_out}, 32'd0);
        instr_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        do_op(MD_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 33, d1); bubble();

        do_op(MD_DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 1, d1); bubble();
        do_op(MD_REM, 32'd7, 32'd0, 5'd11, 32'd7, 1, d1); bubble();
        do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1, d1); bubble();
        do_op(MD_REM, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, 1, d1); bubble();

        // flush in BUSY cycle 10 aborts the op without a result strobe
        @(posedge clk); #1;
        instr_valid = 1'b1;
        instruction = mk(F7_MULDIV, MD_MUL, 5'd14);
        rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd14;
        #1;
        chk("flush_start_stall", {31'd0, stall_o}, 32'd1);
        repeat (10) @(posedge clk);
        #2;
        chk("flush_pre_stall", {31'd0, stall_o}, 32'd1);
        flush = 1'b1; #1;
        chk("flush_stall", {31'd0, stall_o}, 32'd0);
        chk("flush_valid", {31'd0, result_valid}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            chk("post_flush_valid", {31'd0, result_valid}, 32'd0);
            chk("post_flush_stall", {31'd0, stall_o}, 32'd0);
            @(posedge clk); #1;
        end

        // non-M instruction and an invalid M instruction never stall
        instruction = mk(7'b0000000, 3'd0, 5'd15);
        instr_valid = 1'b1; #1;
        chk("add_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #2;
        chk("add_valid", {31'd0, result_valid}, 32'd0);
        chk("add_stall2", {31'd0, stall_o}, 32'd0);
        instr_valid = 1'b0;
        instruction = mk(F7_MULDIV, MD_MUL, 5'd16); #1;
        chk("inval_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #2;
        chk("inval_valid", {31'd0, result_valid}, 32'd0);
        chk("inval_stall2", {31'd0, stall_o}, 32'd0);

        do_op(MD_MUL, 32'd3, 32'd5, 5'd7, 32'd15, 33, d1);
        do_op(MD_MUL, 32'd6, 32'd7, 5'd9, 32'd42, 33, d2);
        chk("b2b_spacing", d2 - d1, 32'd34);
        bubble();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
